// File: rtl/u_balance_update.sv
// Account balance store with a 4-state commit FSM for deposit/withdraw transactions.
// Rejected transactions leave the store untouched; rd_balance is a pure mux of the store.
`timescale 1ns/1ps
module u_balance_update #(
  parameter int CIS           = 4,
  parameter int DBD           = 16,
  parameter int balance_width = 14,
  parameter int AMT_W         = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CIS-1:0]           rd_index,
  output logic [balance_width-1:0] rd_balance,
  input  logic                     req,
  input  logic                     op,
  input  logic [CIS-1:0]           tx_index,
  input  logic [AMT_W-1:0]         amount,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               status,
  output logic [balance_width-1:0] new_balance
);

  // Comparison width is one bit wider than the widest operand so the deposit sum never wraps.
  localparam int SW = ((AMT_W > balance_width) ? AMT_W : balance_width) + 1;
  localparam logic [SW-1:0] MAX_BAL = SW'((64'd1 << balance_width) - 64'd1);

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_INSUFF = 2'b01;
  localparam logic [1:0] ST_OVF    = 2'b10;
  localparam logic [1:0] ST_ZERO   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     op_q, op_d;
  logic [CIS-1:0]           idx_q, idx_d;
  logic [AMT_W-1:0]         amt_q, amt_d;
  logic [1:0]               dec_q, dec_d;
  logic [balance_width-1:0] res_q, res_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [1:0]               status_q, status_d;
  logic [balance_width-1:0] nb_q, nb_d;
  logic [balance_width-1:0] bal_q [DBD];
  logic [balance_width-1:0] bal_d [DBD];

  logic [balance_width-1:0] cur_bal;
  logic [SW-1:0]            ext_bal, ext_amt, sum, diff;

  assign rd_balance  = bal_q[rd_index];
  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign new_balance = nb_q;

  assign cur_bal = bal_q[idx_q];
  assign ext_bal = SW'(cur_bal);
  assign ext_amt = SW'(amt_q);
  assign sum     = ext_bal + ext_amt;
  assign diff    = ext_bal - ext_amt;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    amt_d    = amt_q;
    dec_d    = dec_q;
    res_d    = res_q;
    busy_d   = busy_q;
    done_d   = done_q;
    status_d = status_q;
    nb_d     = nb_q;
    bal_d    = bal_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          idx_d   = tx_index;
          amt_d   = amount;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        res_d = cur_bal;
        if (amt_q == '0) begin
          dec_d = ST_ZERO;
        end else if (!op_q && (ext_amt > ext_bal)) begin
          dec_d = ST_INSUFF;
        end else if (op_q && (sum > MAX_BAL)) begin
          dec_d = ST_OVF;
        end else begin
          dec_d = ST_OK;
          res_d = op_q ? balance_width'(sum) : balance_width'(diff);
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (dec_q == ST_OK) bal_d[idx_q] = res_q;
        nb_d     = res_q;
        status_d = dec_q;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      idx_q    <= '0;
      amt_q    <= '0;
      dec_q    <= ST_OK;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      nb_q     <= '0;
      for (int i = 0; i < DBD; i++) bal_q[i] <= balance_width'(1500 + 500 * i);
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      amt_q    <= amt_d;
      dec_q    <= dec_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      nb_q     <= nb_d;
      bal_q    <= bal_d;
    end
  end

endmodule

// File: tb/tb_u_balance_update.sv
// Directed bench for u_balance_update: expected results queued at drive time, popped on done.
`timescale 1ns/1ps
module tb_u_balance_update;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_index;
  logic [13:0] rd_balance;
  logic        req;
  logic        op;
  logic [3:0]  tx_index;
  logic [13:0] amount;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [13:0] new_balance;

  u_balance_update dut (
    .clk(clk), .rst_n(rst_n), .rd_index(rd_index), .rd_balance(rd_balance),
    .req(req), .op(op), .tx_index(tx_index), .amount(amount),
    .busy(busy), .done(done), .status(status), .new_balance(new_balance)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [13:0] nb;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [13:0] model [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) model[i] = 14'(1500 + 500 * i);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed done with empty scoreboard expected queued result", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_status"}, 32'(status), 32'(e.st));
      chk({tag, "_newbal"}, 32'(new_balance), 32'(e.nb));
    end
  endtask

  task automatic check_all_reads(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_balance), 32'(model[i]));
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_tx(input string tag, input logic o, input logic [3:0] idx,
                       input logic [13:0] amt, input logic [1:0] exp_st);
    exp_t        e;
    logic [13:0] old;
    old  = model[idx];
    e.st = exp_st;
    if (exp_st != 2'b00) e.nb = old;
    else                 e.nb = o ? 14'(old + amt) : 14'(old - amt);
    sb_q.push_back(e);
    req = 1'b1; op = o; tx_index = idx; amount = amt; rd_index = idx;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req = 1'b0;
      chk($sformatf("%s_busy_c%0d", tag, k), 32'(busy), (k <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("%s_done_c%0d", tag, k), 32'(done), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) chk($sformatf("%s_rd_old_c%0d", tag, k), 32'(rd_balance), 32'(old));
      if (k == 3) begin
        pop_chk(tag);
        chk({tag, "_rd_new"}, 32'(rd_balance), 32'(e.nb));
      end
    end
    model[idx] = e.nb;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b1; req = 1'b0; op = 1'b0; tx_index = '0; amount = '0; rd_index = '0;
    reset_model();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_newbal", 32'(new_balance), 32'd0);
    check_all_reads("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_tx("wd500_i0",    1'b0, 4'd0,  14'd500,  2'b00);
    do_tx("wd2001_i1",   1'b0, 4'd1,  14'd2001, 2'b01);
    do_tx("wd2000_i1",   1'b0, 4'd1,  14'd2000, 2'b00);
    do_tx("wd1_empty",   1'b0, 4'd1,  14'd1,    2'b01);
    do_tx("dep8000_i15", 1'b1, 4'd15, 14'd8000, 2'b10);
    do_tx("dep7383_i15", 1'b1, 4'd15, 14'd7383, 2'b00);
    do_tx("dep1_full",   1'b1, 4'd15, 14'd1,    2'b10);
    do_tx("dep0_i5",     1'b1, 4'd5,  14'd0,    2'b11);
    do_tx("wd0_i1",      1'b0, 4'd1,  14'd0,    2'b11);
    do_tx("dep0_full",   1'b1, 4'd15, 14'd0,    2'b11);
    chk("final_i0", 32'(model[0]), 32'd1000);
    chk("final_i15", 32'(model[15]), 32'd16383);

    // req held high across a busy window: second request waits for IDLE.
    e.st = 2'b00; e.nb = 14'd2400; sb_q.push_back(e);
    req = 1'b1; op = 1'b0; tx_index = 4'd2; amount = 14'd100;
    @(posedge clk);
    @(negedge clk);
    op = 1'b1; tx_index = 4'd4; amount = 14'd200;
    e.st = 2'b00; e.nb = 14'd3700; sb_q.push_back(e);
    chk("hold_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("hold_done_c2", 32'(done), 32'd0);
    @(negedge clk);
    chk("hold_done_c3", 32'(done), 32'd1);
    pop_chk("hold_first");
    @(negedge clk);
    chk("hold_busy_c4", 32'(busy), 32'd0);
    chk("hold_done_c4", 32'(done), 32'd0);
    @(negedge clk);
    req = 1'b0;
    chk("hold_busy_c5", 32'(busy), 32'd1);
    @(negedge clk);
    chk("hold_done_c6", 32'(done), 32'd0);
    @(negedge clk);
    chk("hold_done_c7", 32'(done), 32'd1);
    pop_chk("hold_second");
    @(negedge clk);
    chk("hold_busy_c8", 32'(busy), 32'd0);
    model[2] = 14'd2400;
    model[4] = 14'd3700;
    check_all_reads("post_hold");

    // Reset asserted while the FSM sits in WRITE.
    req = 1'b1; op = 1'b0; tx_index = 4'd3; amount = 14'd100; rd_index = 4'd3;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_done", 32'(done), 32'd0);
    chk("rstw_i3", 32'(rd_balance), 32'd3000);
    rd_index = 4'd0;
    #1;
    chk("rstw_i0", 32'(rd_balance), 32'd1500);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstw_nodone_%0d", k), 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstw_idle_done_%0d", k), 32'(done), 32'd0);
    end
    check_all_reads("post_rstw");
    do_tx("post_rst_wd", 1'b0, 4'd3, 14'd100, 2'b00);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
